oled_i2c_target: RTL and testbench

OLED_I2C_TARGET -- requirements
Module: oled_i2c_target

---
 rtl/oled_i2c_target.sv | 181 ++++++++++++++++++
 tb/tb_oled_i2c_target.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/oled_i2c_target.sv
// oled_i2c_target
//   Write-only I2C target for an SSD1306-style OLED controller interface.
//   Decodes START/STOP, matches a 7-bit device address, then alternates
//   control bytes (Co, D/C#) and payload bytes, acknowledging every byte.
//
// Parameters
//   DEV_ADDR     7-bit I2C address this target answers to
//   SYNC_STAGES  synchronizer depth for scl and sda_i (>= 2)
//
// Ports
//   clk            system clock (>= 20x SCL)
//   reset          asynchronous active-low reset
//   scl, sda_i     I2C bus inputs from the pads
//   sda_oe         open-drain pull-down enable (1 = drive SDA low)
//   rx_data        last received payload byte
//   rx_cmd_valid   pulse: rx_data is a command byte
//   rx_data_valid  pulse: rx_data is a display-data byte
//   frame_start    pulse on address match with write
//   frame_end      pulse when an addressed frame ends (STOP or repeated START)
//   busy           high from address match until the end of the frame
//   addr_nack      pulse when an address byte is not acknowledged
module oled_i2c_target #(
  parameter logic [6:0]  DEV_ADDR    = 7'h3C,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_cmd_valid,
  output logic       rx_data_valid,
  output logic       frame_start,
  output logic       frame_end,
  output logic       busy,
  output logic       addr_nack
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, CTRL, CTRL_ACK, PAYLOAD, PAYLOAD_ACK, IGNORE
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic scl_s, sda_s;
  logic scl_q, sda_q;
  logic scl_rise, scl_fall;
  logic start_det, stop_det;

  logic [2:0] bit_cnt;
  logic [6:0] shift;
  logic [7:0] byte_val;
  logic       byte_done;
  logic       ack_on;
  logic       co;
  logic       dc;

  // Synchronizers reset to 1 so an idle-high bus shows no edge on release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
    end
  end

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_q;
  assign scl_fall = ~scl_s & scl_q;

  // scl must be high in both samples; sda can only move one way per cycle,
  // so START and STOP are mutually exclusive by construction.
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

  assign byte_val  = {shift, sda_s};
  assign byte_done = scl_rise && (bit_cnt == 3'd7);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      sda_oe        <= 1'b0;
      rx_data       <= '0;
      rx_cmd_valid  <= 1'b0;
      rx_data_valid <= 1'b0;
      frame_start   <= 1'b0;
      frame_end     <= 1'b0;
      busy          <= 1'b0;
      addr_nack     <= 1'b0;
      bit_cnt       <= '0;
      shift         <= '0;
      ack_on        <= 1'b0;
      co            <= 1'b0;
      dc            <= 1'b0;
    end else begin
      rx_cmd_valid  <= 1'b0;
      rx_data_valid <= 1'b0;
      frame_start   <= 1'b0;
      frame_end     <= 1'b0;
      addr_nack     <= 1'b0;

      if (start_det || stop_det) begin
        // Bus condition overrides everything; any partial byte is dropped.
        if (busy) frame_end <= 1'b1;
        busy    <= 1'b0;
        bit_cnt <= '0;
        ack_on  <= 1'b0;
        sda_oe  <= 1'b0;
        state   <= start_det ? ADDR : IDLE;
      end else begin
        case (state)
          ADDR, CTRL, PAYLOAD: begin
            if (scl_rise) begin
              shift   <= {shift[5:0], sda_s};
              bit_cnt <= bit_cnt + 3'd1;
            end
            if (byte_done) begin
              bit_cnt <= '0;
              ack_on  <= 1'b0;
              case (state)
                ADDR: begin
                  if (byte_val[7:1] == DEV_ADDR && !byte_val[0]) begin
                    frame_start <= 1'b1;
                    busy        <= 1'b1;
                    state       <= ADDR_ACK;
                  end else begin
                    addr_nack <= 1'b1;
                    state     <= IGNORE;
                  end
                end
                CTRL: begin
                  co    <= byte_val[7];
                  dc    <= byte_val[6];
                  state <= CTRL_ACK;
                end
                default: begin
                  rx_data       <= byte_val;
                  rx_cmd_valid  <= ~dc;
                  rx_data_valid <= dc;
                  state         <= PAYLOAD_ACK;
                end
              endcase
            end
          end

          // First scl fall after bit 8 pulls SDA low; the fall ending the
          // 9th clock releases it and moves on.
          ADDR_ACK, CTRL_ACK, PAYLOAD_ACK: begin
            if (scl_fall) begin
              if (!ack_on) begin
                ack_on <= 1'b1;
                sda_oe <= 1'b1;
              end else begin
                ack_on <= 1'b0;
                sda_oe <= 1'b0;
                case (state)
                  ADDR_ACK: state <= CTRL;
                  CTRL_ACK: state <= PAYLOAD;
                  default:  state <= co ? CTRL : PAYLOAD;
                endcase
              end
            end
          end

          default: ; // IDLE and IGNORE wait for START/STOP
        endcase
      end
    end
  end

endmodule

// File: tb/tb_oled_i2c_target.sv
`timescale 1ns/1ps
module tb_oled_i2c_target;

  localparam int Q = 60; // quarter SCL period; SCL = 24 clk

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic sda_bus;
  logic sda_oe;
  logic [7:0] rx_data;
  logic rx_cmd_valid, rx_data_valid, frame_start, frame_end, busy, addr_nack;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // open-drain wired-AND of controller and target
  assign sda_bus = sda_m & ~sda_oe;

  oled_i2c_target #(.DEV_ADDR(7'h3C), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .scl(scl_m), .sda_i(sda_bus),
    .sda_oe(sda_oe), .rx_data(rx_data), .rx_cmd_valid(rx_cmd_valid),
    .rx_data_valid(rx_data_valid), .frame_start(frame_start),
    .frame_end(frame_end), .busy(busy), .addr_nack(addr_nack)
  );

  // Monitor: single writer of all observation counters/queues.
  logic [8:0] got[$];
  int fs_cnt = 0, fe_cnt = 0, nk_cnt = 0, oe_cnt = 0, both_cnt = 0;

  always @(negedge clk) begin
    if (rx_cmd_valid)  got.push_back({1'b0, rx_data});
    if (rx_data_valid) got.push_back({1'b1, rx_data});
    if (rx_cmd_valid && rx_data_valid) both_cnt++;
    if (frame_start) fs_cnt++;
    if (frame_end)   fe_cnt++;
    if (addr_nack)   nk_cnt++;
    if (sda_oe)      oe_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic i2c_start();
    if (scl_m == 1'b0) begin
      sda_m = 1'b1; #(Q);
      scl_m = 1'b1; #(Q);
    end else begin
      sda_m = 1'b1; #(Q);
    end
    sda_m = 1'b0; #(Q);
    scl_m = 1'b0; #(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #(Q);
    scl_m = 1'b1; #(Q);
    sda_m = 1'b1; #(2*Q);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;    #(Q);
    scl_m = 1'b1; #(2*Q);
    scl_m = 1'b0; #(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; #(Q);
    scl_m = 1'b1; #(Q);
    ack = sda_bus;  #(Q);
    scl_m = 1'b0; #(Q);
  endtask

  // Reference model: after the address, bytes alternate control/payload;
  // a control byte with Co=0 makes every following byte payload.
  logic [7:0] tx[$];
  logic [8:0] exp_ev[$];

  task automatic model_frame();
    bit expect_ctrl = 1'b1;
    bit m_co = 1'b0, m_dc = 1'b0;
    exp_ev.delete();
    foreach (tx[i]) begin
      if (expect_ctrl) begin
        m_co = tx[i][7];
        m_dc = tx[i][6];
        expect_ctrl = 1'b0;
      end else begin
        exp_ev.push_back({m_dc, tx[i]});
        expect_ctrl = m_co;
      end
    end
  endtask

  task automatic run_frame(input string tag, input logic [7:0] addr,
                           input bit skip_start, input bit end_restart);
    int base, fs0, fe0, nk0, oe0;
    bit match;
    logic a;
    base = got.size(); fs0 = fs_cnt; fe0 = fe_cnt; nk0 = nk_cnt; oe0 = oe_cnt;
    match = (addr[7:1] == 7'h3C) && !addr[0];
    if (!skip_start) i2c_start();
    send_byte(addr, a);
    chk({tag, " addr ack"}, a, match ? 0 : 1);
    if (match) begin
      foreach (tx[i]) begin
        send_byte(tx[i], a);
        chk({tag, " byte ack"}, a, 0);
      end
      model_frame();
    end else begin
      exp_ev.delete();
    end
    if (end_restart) i2c_start(); else i2c_stop();
    repeat (4) @(negedge clk);
    chk({tag, " event count"}, got.size() - base, exp_ev.size());
    foreach (exp_ev[i])
      if (base + i < got.size())
        chk({tag, " event"}, got[base + i], exp_ev[i]);
    chk({tag, " frame_start"}, fs_cnt - fs0, match ? 1 : 0);
    chk({tag, " frame_end"}, fe_cnt - fe0, match ? 1 : 0);
    chk({tag, " addr_nack"}, nk_cnt - nk0, match ? 0 : 1);
    chk({tag, " busy"}, busy, 0);
    if (!match) chk({tag, " sda_oe quiet"}, oe_cnt - oe0, 0);
  endtask

  initial begin
    int base, fe0;
    logic a;
    logic [3:0] nib;

    repeat (4) @(negedge clk);
    chk("reset sda_oe", sda_oe, 0);
    chk("reset rx_data", rx_data, 8'h00);
    chk("reset cmd_valid", rx_cmd_valid, 0);
    chk("reset data_valid", rx_data_valid, 0);
    chk("reset frame_start", frame_start, 0);
    chk("reset frame_end", frame_end, 0);
    chk("reset busy", busy, 0);
    chk("reset addr_nack", addr_nack, 0);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("no false start", fs_cnt + nk_cnt, 0);

    tx = '{8'h00, 8'hAE, 8'hAF};
    run_frame("cmd stream", 8'h78, 0, 0);
    tx = '{8'h40, 8'h12, 8'h34};
    run_frame("data stream", 8'h78, 0, 0);
    tx = '{8'h80, 8'h8D, 8'hC0, 8'h55};
    run_frame("mixed co", 8'h78, 0, 0);

    tx.delete();
    run_frame("nack 7A", 8'h7A, 0, 1);
    run_frame("nack 79", 8'h79, 1, 0);
    run_frame("addr only", 8'h78, 0, 0);

    // STOP after 4 bits of a payload byte
    base = got.size(); fe0 = fe_cnt;
    i2c_start();
    send_byte(8'h78, a); chk("partial addr ack", a, 0);
    send_byte(8'h40, a); chk("partial ctrl ack", a, 0);
    nib = 4'b1010;
    for (int i = 3; i >= 0; i--) send_bit(nib[i]);
    i2c_stop();
    repeat (4) @(negedge clk);
    chk("partial no valid", got.size() - base, 0);
    chk("partial frame_end", fe_cnt - fe0, 1);
    chk("partial busy", busy, 0);
    tx = '{8'h00, 8'hA5};
    run_frame("after partial", 8'h78, 0, 0);

    // Reset during the ACK of the control byte
    i2c_start();
    send_byte(8'h78, a);
    for (int i = 7; i >= 0; i--) send_bit(1'b0);
    sda_m = 1'b1; #(Q);
    chk("ack driven before reset", sda_oe, 1);
    reset = 1'b0; #1;
    chk("async release sda_oe", sda_oe, 0);
    #9;
    scl_m = 1'b1; sda_m = 1'b1;
    repeat (4) @(negedge clk);
    chk("busy in reset", busy, 0);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    tx = '{8'h80, 8'h21, 8'h40, 8'h3C};
    run_frame("after reset", 8'h78, 0, 0);

    // Randomized frames, occasionally mis-addressed or ended by restart
    begin
      bit restart_prev = 1'b0;
      for (int f = 0; f < 20; f++) begin
        logic [7:0] addr;
        bit rs;
        addr = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h78;
        rs = ($urandom_range(0, 3) == 0);
        tx.delete();
        for (int n = $urandom_range(0, 6); n > 0; n--) tx.push_back(8'($urandom));
        run_frame("random", addr, restart_prev, rs);
        restart_prev = rs;
      end
      if (restart_prev) begin
        i2c_stop();
        repeat (4) @(negedge clk);
      end
    end

    chk("cmd/data exclusive", both_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
